// File: rtl/data_memory_pkg.sv
// Shared types and defaults for the data memory controller.
// Optional parity feature: DATA_MEMORY_PARITY_EN.
package data_memory_pkg;

    localparam int DEPTH_DEF      = 1024;
    localparam int ADDR_WIDTH_DEF = 12;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

endpackage

// File: rtl/data_memory_if.sv
// Request/response bus of the data memory controller.
// Optional parity feature: DATA_MEMORY_PARITY_EN (no bus change).
interface data_memory_if
    import data_memory_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_error;

    modport master (
        output req_valid, req_write, req_addr,
        output req_size, req_unsigned, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr,
        input  req_size, req_unsigned, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/dmem_array.sv
// Word storage with byte-lane write enables and registered read.
// Parity bits per lane stored when DATA_MEMORY_PARITY_EN is defined.
module dmem_array
    import data_memory_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [AW-1:0] addr_i,
    input  logic [3:0]    we_i,
    input  logic [31:0]   wdata_i,
    input  logic          re_i,
    output logic [31:0]   rdata_o
`ifdef DATA_MEMORY_PARITY_EN
    ,
    input  logic [3:0]    wpar_i,
    output logic [3:0]    rpar_o
`endif
);
    logic [3:0][7:0] mem_q [DEPTH];
    logic [31:0]     rdata_q;

    // Lane writes; contents come from the init sweep, not from reset.
    always_ff @(posedge clock) begin
        for (int l = 0; l < 4; l++) begin
            if (we_i[l]) mem_q[addr_i][l] <= wdata_i[8*l +: 8];
        end
    end

    // Registered read port.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)  rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

`ifdef DATA_MEMORY_PARITY_EN
    logic [3:0] par_q [DEPTH];
    logic [3:0] rpar_q;

    // Parity bit per lane follows its data lane.
    always_ff @(posedge clock) begin
        for (int l = 0; l < 4; l++) begin
            if (we_i[l]) par_q[addr_i][l] <= wpar_i[l];
        end
    end

    // Parity read alongside the data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)  rpar_q <= '0;
        else if (re_i) rpar_q <= par_q[addr_i];
    end

    assign rpar_o = rpar_q;
`endif

endmodule

// File: rtl/data_memory_ctrl.sv
// Data memory controller: clear sweep, lane alignment, load extension.
// Optional per-lane parity: define DATA_MEMORY_PARITY_EN.
module data_memory_ctrl
    import data_memory_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic         clock,
    input  logic         reset_n,
    data_memory_if.slave bus,
    output logic         init_busy
`ifdef DATA_MEMORY_PARITY_EN
    ,
    input  logic         par_inject
`endif
);
    localparam int AW = ADDR_WIDTH - 2;

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    size_e       sz;
    logic [1:0]  off;
    logic [3:0]  be;
    logic        bad;
    logic [31:0] wdata_al;
    logic        acc;

    logic [AW-1:0] arr_addr;
    logic [3:0]    arr_we;
    logic [31:0]   arr_wdata;
    logic          arr_re;
    logic [31:0]   arr_rdata;

    logic       rsp_valid_q, err_q, load_q, uns_q;
    size_e      size_q;
    logic [1:0] off_q;

    logic [31:0] shifted, ext;
    logic        par_err;

    assign sz  = size_e'(bus.req_size);
    assign off = bus.req_addr[1:0];
    assign acc = bus.req_valid & (state_q == READY);

    assign init_busy     = (state_q == INIT);
    assign bus.req_ready = (state_q == READY);

    // Lane enables, alignment faults and store data replication.
    always_comb begin
        be       = 4'b0000;
        bad      = 1'b0;
        wdata_al = bus.req_wdata;
        unique case (sz)
            SZ_BYTE: begin
                be       = 4'b0001 << off;
                wdata_al = {4{bus.req_wdata[7:0]}};
            end
            SZ_HALF: begin
                be       = 4'b0011 << off;
                bad      = off[0];
                wdata_al = {2{bus.req_wdata[15:0]}};
            end
            SZ_WORD: begin
                be  = 4'b1111;
                bad = (off != 2'b00);
            end
            SZ_ILL: begin
                bad = 1'b1;
            end
        endcase
    end

    // Sweep owns the array in INIT; accepted requests drive it in READY.
    always_comb begin
        arr_addr  = bus.req_addr[ADDR_WIDTH-1:2];
        arr_we    = 4'b0000;
        arr_wdata = wdata_al;
        arr_re    = 1'b0;
        if (state_q == INIT) begin
            arr_addr  = cnt_q;
            arr_we    = 4'b1111;
            arr_wdata = '0;
        end else begin
            arr_we = (acc & bus.req_write & ~bad) ? be : 4'b0000;
            arr_re = acc & ~bus.req_write & ~bad;
        end
    end

    // Next-state logic for the clear sweep.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            INIT: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1)) state_d = READY;
            end
            READY: ;
        endcase
    end

    // FSM and sweep counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Response bookkeeping captured at the accepting edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            load_q      <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= SZ_BYTE;
            off_q       <= 2'b00;
        end else begin
            rsp_valid_q <= acc;
            err_q       <= acc & bad;
            load_q      <= arr_re;
            uns_q       <= bus.req_unsigned;
            size_q      <= sz;
            off_q       <= off;
        end
    end

    // Shift the addressed lanes to bit 0 and extend.
    always_comb begin
        shifted = arr_rdata >> {off_q, 3'b000};
        ext     = shifted;
        unique case (size_q)
            SZ_BYTE: ext = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
            SZ_HALF: ext = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

`ifdef DATA_MEMORY_PARITY_EN
    logic [3:0] arr_wpar, arr_rpar, calc_par, be_q;

    // Stored parity; an injected store flips every written lane.
    always_comb begin
        arr_wpar = 4'b0000;
        calc_par = 4'b0000;
        for (int l = 0; l < 4; l++) begin
            arr_wpar[l] = ^arr_wdata[8*l +: 8] ^
                          (par_inject & (state_q == READY));
            calc_par[l] = ^arr_rdata[8*l +: 8];
        end
    end

    // Lanes a load touched, so only those are checked.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) be_q <= 4'b0000;
        else          be_q <= be;
    end

    assign par_err = load_q & |(be_q & (calc_par ^ arr_rpar));

    dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
        .clock   (clock),
        .reset_n (reset_n),
        .addr_i  (arr_addr),
        .we_i    (arr_we),
        .wdata_i (arr_wdata),
        .re_i    (arr_re),
        .rdata_o (arr_rdata),
        .wpar_i  (arr_wpar),
        .rpar_o  (arr_rpar)
    );
`else
    assign par_err = 1'b0;

    dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
        .clock   (clock),
        .reset_n (reset_n),
        .addr_i  (arr_addr),
        .we_i    (arr_we),
        .wdata_i (arr_wdata),
        .re_i    (arr_re),
        .rdata_o (arr_rdata)
    );
`endif

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_error = err_q | par_err;
    assign bus.rsp_rdata = (load_q & ~par_err) ? ext : 32'h0;

endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 Parameter DEPTH, default 1024, number of 32-bit words stored; a power of two, at least 4.
REQ-002 Parameter ADDR_WIDTH, default 12, byte-address width; SHALL equal log2(DEPTH)+2.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  access request present.
REQ-006 req_ready  output  1  request accepted this cycle when high together with req_valid.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  ADDR_WIDTH  byte address.
REQ-009 req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-010 req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend.
REQ-011 req_wdata  input  32  store data, right-aligned.
REQ-012 rsp_valid  output  1  one-cycle response strobe.
REQ-013 rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-014 rsp_error  output  1  access rejected or corrupted; qualified by rsp_valid.
REQ-015 init_busy  output  1  memory clear sweep in progress.

Function
REQ-016 FSM states INIT, READY; reset enters INIT.
REQ-017 INIT: clear counter starts at 0, writes word 0 to the location it addresses each cycle, increments; after word DEPTH-1 is written, next state is READY. Sweep takes DEPTH cycles; init_busy high throughout.
REQ-018 req_ready SHALL be 0 in INIT and 1 in READY; requests in INIT are ignored, not queued.
REQ-019 Accepted request at edge N produces rsp_valid high exactly in cycle N+1; back-to-back accepts yield back-to-back responses; no response backpressure.
REQ-020 Store: byte lanes selected by req_addr[1:0] and req_size; only the selected lanes change; write completes at the accepting edge.
REQ-021 Load: addressed lanes extracted, shifted to bit 0, extended per req_unsigned; rsp_rdata valid with rsp_valid.
REQ-022 Load accepted in the cycle after a store to the same word SHALL return the stored data.
REQ-023 Error (rsp_error=1, rsp_rdata=0, memory unchanged): req_size=11; halfword with addr[0]=1; word with addr[1:0]!=0.
REQ-024 rsp_valid, rsp_rdata, rsp_error registered; 0 in every cycle without a response.

Reset
REQ-025 reset_n low: FSM=INIT, clear counter=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, init_busy=1, req_ready=0.
REQ-026 Reset asserted mid-sweep or mid-access aborts it; sweep restarts from word 0 after release; in-flight response is dropped.

Configuration
REQ-027 Macro DATA_MEMORY_PARITY_EN: when defined, one even-parity bit per byte lane stored, written on stores and by the sweep, checked on loads over the accessed lanes only; mismatch sets rsp_error=1 with rsp_rdata=0. Adds input par_inject (1 bit): inverts stored parity of written lanes for that store.
REQ-028 Without DATA_MEMORY_PARITY_EN: no parity storage, no par_inject port, rsp_error only per REQ-023.

Structure
REQ-029 Shared package data_memory_pkg holds the req_size encodings, the FSM state type and the DEPTH/ADDR_WIDTH defaults.
REQ-030 Storage array (per-lane write enables, registered read, optional parity bits) SHALL be sub-module dmem_array; lane alignment and extension and the FSM stay in data_memory_ctrl.

Verification
REQ-031 Reset release, DEPTH=16 -> init_busy high 16 cycles, req_ready rises cycle 17; word loads of addrs 0x0-0x3C return 0.
REQ-032 Store word 0xDEADBEEF at 0x8, then byte load 0xB signed -> 0xFFFFFFDE; unsigned -> 0x000000DE; halfword load 0x8 signed -> 0xFFFFBEEF.
REQ-033 Store byte 0x5A at 0x9 over 0xDEADBEEF -> word load 0x8 returns 0xDEAD5AEF; next-cycle load after store sees new data.
REQ-034 Halfword load at 0x3, word store at 0x6, req_size=11 -> rsp_error=1, rsp_rdata=0, target word unchanged.
REQ-035 reset_n pulsed low at sweep cycle 5 -> sweep restarts, init_busy high another DEPTH cycles, no rsp_valid.
REQ-036 DATA_MEMORY_PARITY_EN: store word 0x12345678 at 0x4 with par_inject=1 -> load 0x4 rsp_error=1; byte load at 0x4 errors; rewrite without inject -> load returns 0x12345678, rsp_error=0.
